lane_serializer: RTL

- Parametrised successor to the single-bit shift serializer.
- Accepts a DATA_W-bit parallel word over a valid/ready handshake and emits it as DATA_W/LANE_W lanes of LANE_W bits, with a selectable bit order.
- Output side has full valid/ready backpressure and a last-beat marker.
- Sits between word-wide datapath logic and narrow link/PHY-side interfaces; back-to-back words stream with no idle cycle.

---
 rtl/ser_pkg.sv | 19 +
 rtl/lane_serializer.sv | 90 +++++++++
 2 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the lane serializer and its companion deserializer.
// Holds the FSM state type and the lane-count / counter-width helpers.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    function automatic int beats(input int data_w, input int lane_w);
        return (lane_w > 0) ? data_w / lane_w : 1;
    endfunction

    // Counter holds 0..beats, so it needs room for beats itself.
    function automatic int cnt_w(input int n_beats);
        return (n_beats < 1) ? 1 : $clog2(n_beats + 1);
    endfunction

endpackage

// File: rtl/lane_serializer.sv
// Serializes a DATA_W-bit word into DATA_W/LANE_W lanes of LANE_W bits.
// A new word loads on the last-lane handshake, so back-to-back words stream without a bubble.
module lane_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LANE_W    = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [LANE_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o
);

    localparam int BEATS = beats(DATA_W, LANE_W);
    localparam int CW    = cnt_w(BEATS);

    if (DATA_W < 1 || LANE_W == 0 || (DATA_W % LANE_W) != 0) begin : g_bad_params
        $error("lane_serializer: LANE_W must be non-zero and divide DATA_W");
    end

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_next;
    logic              lane_hs;

    // Both sides use valid/ready: a transfer happens on a rising clk edge where
    // valid and ready are both high; once raised, out_valid_o holds and the
    // presented lane/last stay stable until accepted. in_ready_o may depend
    // combinationally on out_ready_i so the next word loads on the last lane.
    assign out_valid_o = (state_q == SHIFT);
    assign out_last_o  = out_valid_o && (cnt_q == CW'(1));
    assign out_data_o  = MSB_FIRST ? sh_q[DATA_W-1 -: LANE_W] : sh_q[LANE_W-1:0];
    assign lane_hs     = out_valid_o && out_ready_i;
    assign in_ready_o  = (state_q == IDLE) || (out_last_o && out_ready_i);

    // Vacated lane is zero-filled so an idle register reads back as zero.
    assign sh_next = MSB_FIRST ? (sh_q << LANE_W) : (sh_q >> LANE_W);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    sh_d    = in_data_i;
                    cnt_d   = CW'(BEATS);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (lane_hs) begin
                    if (out_last_o && in_valid_i) begin
                        sh_d  = in_data_i;
                        cnt_d = CW'(BEATS);
                    end else if (out_last_o) begin
                        sh_d    = sh_next;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        sh_d  = sh_next;
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
